// File: rtl/operand_arbiter_pkg.sv
// operand_arbiter_pkg: shared encodings, limits and helpers for the operand arbiter
package operand_arbiter_pkg;
    localparam logic SRC_REQ1 = 1'b0;
    localparam logic SRC_REQ2 = 1'b1;
    localparam logic [7:0] CNT_MAX = 8'd255;
    typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;
    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == CNT_MAX) ? c : c + 8'd1;
    endfunction
endpackage

// File: rtl/operand_arbiter_mux2.sv
// Mux2: fixed 8-bit two-way data selector (Sel=0 picks Data1)
module Mux2 (
    input  logic [7:0] Data1,
    input  logic [7:0] Data2,
    input  logic       Sel,
    output logic [7:0] Result
);
    assign Result = Sel ? Data2 : Data1;
endmodule

// File: rtl/operand_arbiter.sv
// operand_arbiter: round-robin sharing of one operand path into a single-entry valid/ready output stage
module operand_arbiter
    import operand_arbiter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Req1Valid,
    input  logic [WIDTH-1:0] Req1Data,
    output logic             Req1Ready,
    input  logic             Req2Valid,
    input  logic [WIDTH-1:0] Req2Data,
    output logic             Req2Ready,
    output logic             OutValid,
    output logic [WIDTH-1:0] OutData,
    output logic             OutSrc,
    input  logic             OutReady,
    output logic [7:0]       Grant1Count,
    output logic [7:0]       Grant2Count
);
    state_t           state_q;
    logic [WIDTH-1:0] data_q;
    logic             src_q;
    logic             last_grant_q;
    logic             sel_q;
    logic             sel_d;
    logic             can_load;
    logic             xfer;
    logic [7:0]       cnt1_q;
    logic [7:0]       cnt2_q;
    logic [WIDTH-1:0] mux_result;

    Mux2 u_mux (
        .Data1  (Req1Data),
        .Data2  (Req2Data),
        .Sel    (sel_d),
        .Result (mux_result)
    );

    // Round-robin pick; with no requester the select simply holds
    always_comb begin
        sel_d     = (Req1Valid && Req2Valid) ? ~last_grant_q :
                    Req1Valid ? SRC_REQ1 : Req2Valid ? SRC_REQ2 : sel_q;
        can_load  = (state_q == ST_EMPTY) || OutReady;
        Req1Ready = can_load && Req1Valid && (sel_d == SRC_REQ1);
        Req2Ready = can_load && Req2Valid && (sel_d == SRC_REQ2);
        xfer      = Req1Ready || Req2Ready;
    end

    // Output stage, grant history and saturating grant counters
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= ST_EMPTY;
            data_q       <= '0;
            src_q        <= SRC_REQ1;
            last_grant_q <= SRC_REQ2;
            sel_q        <= SRC_REQ1;
            cnt1_q       <= '0;
            cnt2_q       <= '0;
        end else begin
            sel_q   <= sel_d;
            state_q <= xfer ? ST_FULL : (OutReady ? ST_EMPTY : state_q);
            if (xfer) begin
                data_q       <= mux_result;
                src_q        <= sel_d;
                last_grant_q <= sel_d;
            end
            if (Req1Ready) cnt1_q <= sat_inc(cnt1_q);
            if (Req2Ready) cnt2_q <= sat_inc(cnt2_q);
        end
    end

    assign OutValid    = (state_q == ST_FULL);
    assign OutData     = data_q;
    assign OutSrc      = src_q;
    assign Grant1Count = cnt1_q;
    assign Grant2Count = cnt2_q;
endmodule

// File: tb/tb_operand_arbiter.sv
// tb_operand_arbiter: directed self-checking bench for operand_arbiter
module tb_operand_arbiter;
    logic       Clk, Reset;
    logic       Req1Valid, Req2Valid, Req1Ready, Req2Ready;
    logic [7:0] Req1Data, Req2Data, OutData, Grant1Count, Grant2Count;
    logic       OutValid, OutSrc, OutReady;
    int         cmp = 0;
    int         mism = 0;
    logic       pend1, pend2;

    operand_arbiter #(.WIDTH(8)) dut (
        .Clk(Clk), .Reset(Reset),
        .Req1Valid(Req1Valid), .Req1Data(Req1Data), .Req1Ready(Req1Ready),
        .Req2Valid(Req2Valid), .Req2Data(Req2Data), .Req2Ready(Req2Ready),
        .OutValid(OutValid), .OutData(OutData), .OutSrc(OutSrc), .OutReady(OutReady),
        .Grant1Count(Grant1Count), .Grant2Count(Grant2Count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Requesters must hold Valid until they see Ready
    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pend1 <= 1'b0;
            pend2 <= 1'b0;
        end else begin
            if (pend1 && !Req1Valid) begin mism++; $display("FAIL proto_req1 dropped valid got 0 exp 1"); end
            if (pend2 && !Req2Valid) begin mism++; $display("FAIL proto_req2 dropped valid got 0 exp 1"); end
            pend1 <= Req1Valid && !Req1Ready;
            pend2 <= Req2Valid && !Req2Ready;
        end
    end

    task automatic test_reset;
        Reset = 1'b1; Req1Valid = 0; Req2Valid = 0; Req1Data = 0; Req2Data = 0; OutReady = 0;
        repeat (3) @(negedge Clk);
        cmp++; if (OutValid !== 1'b0) begin mism++; $display("FAIL rst_valid got %b exp 0", OutValid); end
        cmp++; if (OutData !== 8'h00) begin mism++; $display("FAIL rst_data got %h exp 00", OutData); end
        cmp++; if (OutSrc !== 1'b0) begin mism++; $display("FAIL rst_src got %b exp 0", OutSrc); end
        cmp++; if ({Grant1Count, Grant2Count} !== 16'h0) begin mism++; $display("FAIL rst_counts got %h/%h exp 00/00", Grant1Count, Grant2Count); end
        Reset = 1'b0;
    endtask

    task automatic test_single;
        @(negedge Clk);
        Req2Valid = 1; Req2Data = 8'h3C; OutReady = 1;
        #1;
        cmp++; if ({Req1Ready, Req2Ready} !== 2'b01) begin mism++; $display("FAIL single_ready got %b exp 01", {Req1Ready, Req2Ready}); end
        @(negedge Clk);
        Req2Valid = 0;
        cmp++; if (OutValid !== 1'b1) begin mism++; $display("FAIL single_valid got %b exp 1", OutValid); end
        cmp++; if (OutData !== 8'h3C) begin mism++; $display("FAIL single_data got %h exp 3c", OutData); end
        cmp++; if (OutSrc !== 1'b1) begin mism++; $display("FAIL single_src got %b exp 1", OutSrc); end
        cmp++; if (Grant2Count !== 8'd1) begin mism++; $display("FAIL single_cnt2 got %0d exp 1", Grant2Count); end
    endtask

    task automatic test_idle_drain;
        OutReady = 1;
        #1;
        cmp++; if ({Req1Ready, Req2Ready} !== 2'b00) begin mism++; $display("FAIL idle_ready got %b exp 00", {Req1Ready, Req2Ready}); end
        @(negedge Clk);
        cmp++; if (OutValid !== 1'b0) begin mism++; $display("FAIL idle_valid got %b exp 0", OutValid); end
        cmp++; if ({OutSrc, OutData} !== {1'b1, 8'h3C}) begin mism++; $display("FAIL idle_stale got %b/%h exp 1/3c", OutSrc, OutData); end
        cmp++; if ({Grant1Count, Grant2Count} !== {8'd0, 8'd1}) begin mism++; $display("FAIL idle_counts got %0d/%0d exp 0/1", Grant1Count, Grant2Count); end
    endtask

    task automatic test_contention;
        Req1Valid = 1; Req1Data = 8'h11; Req2Valid = 1; Req2Data = 8'h22; OutReady = 1;
        for (int i = 0; i < 6; i++) begin
            #1;
            cmp++; if ({Req1Ready, Req2Ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin mism++; $display("FAIL cont_ready[%0d] got %b exp %b", i, {Req1Ready, Req2Ready}, (i % 2 == 0) ? 2'b10 : 2'b01); end
            @(negedge Clk);
            cmp++; if (OutData !== ((i % 2 == 0) ? 8'h11 : 8'h22)) begin mism++; $display("FAIL cont_data[%0d] got %h exp %h", i, OutData, (i % 2 == 0) ? 8'h11 : 8'h22); end
        end
        cmp++; if ({Grant1Count, Grant2Count} !== {8'd3, 8'd4}) begin mism++; $display("FAIL cont_counts got %0d/%0d exp 3/4", Grant1Count, Grant2Count); end
    endtask

    task automatic test_backpressure;
        OutReady = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            cmp++; if ({Req1Ready, Req2Ready} !== 2'b00) begin mism++; $display("FAIL bp_ready[%0d] got %b exp 00", i, {Req1Ready, Req2Ready}); end
            @(negedge Clk);
            cmp++; if ({OutValid, OutSrc, OutData} !== {1'b1, 1'b1, 8'h22}) begin mism++; $display("FAIL bp_hold[%0d] got %b/%b/%h exp 1/1/22", i, OutValid, OutSrc, OutData); end
        end
        OutReady = 1;
        #1;
        cmp++; if ({Req1Ready, Req2Ready} !== 2'b10) begin mism++; $display("FAIL bp_release_ready got %b exp 10", {Req1Ready, Req2Ready}); end
        @(negedge Clk);
        Req1Valid = 0;
        cmp++; if ({OutValid, OutSrc, OutData} !== {1'b1, 1'b0, 8'h11}) begin mism++; $display("FAIL bp_refill got %b/%b/%h exp 1/0/11", OutValid, OutSrc, OutData); end
        @(negedge Clk);
        Req2Valid = 0;
        cmp++; if ({OutSrc, OutData} !== {1'b1, 8'h22}) begin mism++; $display("FAIL bp_next got %b/%h exp 1/22", OutSrc, OutData); end
        @(negedge Clk);
        cmp++; if ({OutValid, Grant1Count, Grant2Count} !== {1'b0, 8'd4, 8'd5}) begin mism++; $display("FAIL bp_end got %b/%0d/%0d exp 0/4/5", OutValid, Grant1Count, Grant2Count); end
    endtask

    task automatic test_saturation;
        logic [7:0] d;
        int         bad;
        bad = 0;
        Req1Valid = 1; OutReady = 1;
        for (int i = 0; i < 300; i++) begin
            d = 8'(i * 7 + 3);
            Req1Data = d;
            @(negedge Clk);
            if (OutData !== d) bad++;
        end
        Req1Valid = 0;
        cmp++; if (bad !== 0) begin mism++; $display("FAIL sat_flow got %0d bad beats exp 0", bad); end
        cmp++; if (Grant1Count !== 8'd255) begin mism++; $display("FAIL sat_cnt1 got %0d exp 255", Grant1Count); end
        cmp++; if (Grant2Count !== 8'd5) begin mism++; $display("FAIL sat_cnt2 got %0d exp 5", Grant2Count); end
    endtask

    task automatic test_reset_mid;
        Req1Valid = 1; Req1Data = 8'hA5; OutReady = 1;
        @(negedge Clk);
        Req1Valid = 0; OutReady = 0;
        cmp++; if ({OutValid, OutSrc, OutData} !== {1'b1, 1'b0, 8'hA5}) begin mism++; $display("FAIL mid_load got %b/%b/%h exp 1/0/a5", OutValid, OutSrc, OutData); end
        #2 Reset = 1;
        #1;
        cmp++; if ({OutValid, OutSrc, OutData} !== 10'h0) begin mism++; $display("FAIL mid_rst_out got %b/%b/%h exp 0/0/00", OutValid, OutSrc, OutData); end
        cmp++; if ({Grant1Count, Grant2Count} !== 16'h0) begin mism++; $display("FAIL mid_rst_counts got %0d/%0d exp 0/0", Grant1Count, Grant2Count); end
        @(negedge Clk);
        Reset = 0;
        Req1Valid = 1; Req1Data = 8'h11; Req2Valid = 1; Req2Data = 8'h22; OutReady = 1;
        #1;
        cmp++; if ({Req1Ready, Req2Ready} !== 2'b10) begin mism++; $display("FAIL mid_first_grant got %b exp 10", {Req1Ready, Req2Ready}); end
        @(negedge Clk);
        Req1Valid = 0;
        cmp++; if ({OutSrc, OutData, Grant1Count} !== {1'b0, 8'h11, 8'd1}) begin mism++; $display("FAIL mid_after got %b/%h/%0d exp 0/11/1", OutSrc, OutData, Grant1Count); end
        @(negedge Clk);
        Req2Valid = 0;
        cmp++; if ({OutSrc, OutData, Grant2Count} !== {1'b1, 8'h22, 8'd1}) begin mism++; $display("FAIL mid_second got %b/%h/%0d exp 1/22/1", OutSrc, OutData, Grant2Count); end
        @(negedge Clk);
    endtask

    initial begin
        test_reset;
        test_single;
        test_idle_drain;
        test_contention;
        test_backpressure;
        test_saturation;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
        $finish;
    end
endmodule
